// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (RISC-V DIV/DIVU/REM/REMU), one quotient bit per clock.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow in one cycle.
module div_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_qsign;
  logic             r_rsign;
  logic             r_dz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvsr_abs;
  logic             w_dz;
  logic             w_fast;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_calc_done;

  assign w_dvd_abs  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvsr_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign w_dz       = (divisor == '0);

`ifdef DIV_FAST_SPECIAL_EN
  logic w_ovf;
  assign w_ovf  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
  assign w_fast = w_dz | w_ovf;
`else
  assign w_fast = 1'b0;
`endif

  // Partial remainder is below the divisor, so a wrapped WIDTH+1 bit result sets the top bit on borrow.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_dvsr};
  assign w_borrow   = w_trial[WIDTH];
  assign w_rem_next = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // Divide-by-zero leaves |dividend| in the remainder; restoring its sign yields the dividend itself.
  assign w_q_fix     = r_dz ? '1 : (r_qsign ? -r_dvd : r_dvd);
  assign w_r_fix     = r_rsign ? -r_rem : r_rem;
  assign w_calc_done = (r_cnt == CW'(WIDTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = w_fast ? DONE : CALC;
      CALC:    if (w_calc_done) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvsr      <= '0;
      r_qsign     <= 1'b0;
      r_rsign     <= 1'b0;
      r_dz        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (!flush) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= w_dvd_abs;
            r_dvsr  <= w_dvsr_abs;
            r_qsign <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_rsign <= is_signed & dividend[WIDTH-1];
            r_dz    <= w_dz;
            if (w_fast) begin
              r_quotient  <= w_dz ? '1 : dividend;
              r_remainder <= w_dz ? dividend : '0;
            end
          end
        end
        CALC: begin
          if (w_calc_done) begin
            r_quotient  <= w_q_fix;
            r_remainder <= w_r_fix;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;

endmodule
